// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and its memory.
// The fetch unit raises imem_req with imem_addr and holds both until the
// memory answers with a one-cycle imem_ack carrying imem_rdata.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch-unit side: issues requests, receives data.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: receives requests, returns data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch unit.
// Fetches one word at pc, holds it in the instruction register until the
// consumer advances, then steps pc sequentially or to a taken-branch target.
// A misaligned branch target parks the unit in TRAP until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  output logic [31:0]  instr_out,
  output logic [10:0]  ctrl_field,
  output logic [31:0]  pc_out,
  output logic         instr_valid,
  input  logic         advance,
  input  logic         branch_taken,
  input  logic [31:0]  branch_offset,
  output logic         misaligned,
  output logic [15:0]  retired
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    VALID = 2'b01,
    TRAP  = 2'b10
  } state_t;

  // Reset value of the instruction register: addi x0, x0, 0.
  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        misaligned_q;
  logic [15:0] retired_q;
  logic        imem_req_q;
  logic        instr_valid_q;

  logic [31:0] seq_pc;
  logic [31:0] branch_target;

  // Candidate next-pc values; plain 32-bit adds wrap naturally.
  assign seq_pc        = pc_q + 32'(PC_STEP);
  assign branch_target = pc_q + branch_offset;

  // Control FSM with registered handshake outputs: each state only looks at
  // the input that belongs to it, so a stray ack or early advance is inert.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= IR_NOP;
      misaligned_q  <= 1'b0;
      retired_q     <= 16'h0000;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            ir_q          <= imem.imem_rdata;
            state_q       <= VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (advance) begin
            retired_q     <= retired_q + 16'h0001;
            instr_valid_q <= 1'b0;
            if (!branch_taken) begin
              pc_q       <= seq_pc;
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end else if (branch_target[1:0] == 2'b00) begin
              pc_q       <= branch_target;
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end else begin
              misaligned_q <= 1'b1;
              state_q      <= TRAP;
              imem_req_q   <= 1'b0;
            end
          end
        end
        TRAP: begin
          state_q <= TRAP;
        end
        default: begin
          state_q       <= TRAP;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr_out      = ir_q;
  assign pc_out         = pc_q;
  assign instr_valid    = instr_valid_q;
  assign misaligned     = misaligned_q;
  assign retired        = retired_q;

  // Decoder-facing slice of the IR: sign bit, funct3 and opcode.
  assign ctrl_field = {ir_q[31], ir_q[14:12], ir_q[6:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of fetch/advance records plus
// hand-written sequences for stalls, stray inputs, wrap, trap and reset.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_out;
  logic [10:0] ctrl_field;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        advance;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        misaligned;
  logic [15:0] retired;

  fetch_unit_if mif ();

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (mif),
    .instr_out     (instr_out),
    .ctrl_field    (ctrl_field),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .misaligned    (misaligned),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [10:0] ctrl;
  } sb_entry_t;

  typedef struct {
    logic [31:0] fetch_pc;
    logic [31:0] rdata;
    int          lat;
    logic [10:0] exp_ctrl;
    logic        taken;
    logic [31:0] offset;
    logic [31:0] exp_next;
  } vec_t;

  sb_entry_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_of(input logic [31:0] r);
    return {r[31], r[14:12], r[6:0]};
  endfunction

  // Wait (bounded) for a request, stall lat cycles, ack once, then check
  // the delivered instruction against the scoreboard.
  task automatic fetch(input logic [31:0] rdata, input int lat, input logic [10:0] ctrl);
    int          waited;
    logic [31:0] addr;
    sb_entry_t   e;
    waited = 0;
    while (!mif.imem_req && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("fetch_req", {31'b0, mif.imem_req}, 32'd1);
    addr = mif.imem_addr;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("addr_stable", mif.imem_addr, addr);
      check("req_held", {31'b0, mif.imem_req}, 32'd1);
    end
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = rdata;
    sb.push_back('{addr: addr, instr: rdata, ctrl: ctrl});
    @(negedge clk);
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("req_low_valid", {31'b0, mif.imem_req}, 32'd0);
    if (instr_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("pc_out", pc_out, e.addr);
      check("instr_out", instr_out, e.instr);
      check("ctrl_field", {21'b0, ctrl_field}, {21'b0, e.ctrl});
    end
  endtask

  task automatic adv(input logic taken, input logic [31:0] offset);
    advance       = 1'b1;
    branch_taken  = taken;
    branch_offset = offset;
    @(negedge clk);
    advance       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] ret_before;
    logic [31:0] ir_before;

    vecs[0] = '{32'h0000_0000, 32'h0000_0033, 0, 11'h033, 1'b0, 32'h0,         32'h0000_0004};
    vecs[1] = '{32'h0000_0004, 32'h00A5_0513, 2, 11'h013, 1'b0, 32'h0,         32'h0000_0008};
    vecs[2] = '{32'h0000_0008, 32'hFE20_AE23, 2, 11'h523, 1'b0, 32'h0,         32'h0000_000C};
    vecs[3] = '{32'h0000_000C, 32'h0000_4063, 2, 11'h263, 1'b0, 32'h0,         32'h0000_0010};
    vecs[4] = '{32'h0000_0010, 32'hFE00_0EE3, 1, 11'h463, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008};
    vecs[5] = '{32'h0000_0008, 32'h0000_0033, 0, 11'h033, 1'b1, 32'h0000_0100, 32'h0000_0108};
    vecs[6] = '{32'h0000_0108, 32'h00A5_0513, 3, 11'h013, 1'b0, 32'h0,         32'h0000_010C};

    rst            = 1'b1;
    advance        = 1'b0;
    branch_taken   = 1'b0;
    branch_offset  = 32'h0;
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, mif.imem_req}, 32'd1);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc_out, RESET_PC);
    check("rst_ir", instr_out, 32'h0000_0013);
    check("rst_retired", {16'b0, retired}, 32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    rst = 1'b0;

    // Table: fetch with given ack latency, then advance.
    for (int i = 0; i < 7; i++) begin
      check("vec_fetch_pc", mif.imem_addr, vecs[i].fetch_pc);
      fetch(vecs[i].rdata, vecs[i].lat, vecs[i].exp_ctrl);
      adv(vecs[i].taken, vecs[i].offset);
      check("vec_next_pc", pc_out, vecs[i].exp_next);
      check("vec_next_addr", mif.imem_addr, vecs[i].exp_next);
      check("vec_retired", {16'b0, retired}, i + 1);
      check("vec_valid_low", {31'b0, instr_valid}, 32'd0);
    end

    // Advance held during FETCH is ignored.
    advance       = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 32'h40;
    repeat (3) @(negedge clk);
    check("fetch_adv_pc", pc_out, 32'h0000_010C);
    check("fetch_adv_retired", {16'b0, retired}, 32'd7);
    check("fetch_adv_req", {31'b0, mif.imem_req}, 32'd1);
    advance       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;

    // Stray ack during VALID is ignored.
    fetch(32'h0000_0013, 1, ctrl_of(32'h0000_0013));
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    check("stray_ack_ir", instr_out, 32'h0000_0013);
    check("stray_ack_pc", pc_out, 32'h0000_010C);
    check("stray_ack_valid", {31'b0, instr_valid}, 32'd1);
    check("stray_ack_retired", {16'b0, retired}, 32'd7);

    // Branch backwards wraps to the top word; sequential step wraps to 0.
    adv(1'b1, 32'hFFFF_FEF0);
    check("wrap_target", pc_out, 32'hFFFF_FFFC);
    fetch(32'h0000_0033, 0, 11'h033);
    adv(1'b0, 32'h0);
    check("wrap_seq_pc", pc_out, 32'h0000_0000);
    check("wrap_no_flag", {31'b0, misaligned}, 32'd0);
    check("wrap_retired", {16'b0, retired}, 32'd9);

    // Reset pulsed during VALID at pc 0x20.
    fetch(32'h0000_0033, 0, 11'h033);
    adv(1'b1, 32'h0000_0020);
    fetch(32'h00A5_0513, 1, 11'h013);
    check("pre_rst_pc", pc_out, 32'h0000_0020);
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, mif.imem_req}, 32'd1);
    check("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pc", pc_out, RESET_PC);
    check("mid_rst_retired", {16'b0, retired}, 32'd0);

    // Ack in the first cycle after release answers RESET_PC, then a
    // misaligned branch traps.
    fetch(32'h0000_0063, 0, 11'h063);
    ret_before = retired;
    ir_before  = instr_out;
    adv(1'b1, 32'h0000_0006);
    check("trap_misaligned", {31'b0, misaligned}, 32'd1);
    check("trap_req", {31'b0, mif.imem_req}, 32'd0);
    check("trap_valid", {31'b0, instr_valid}, 32'd0);
    check("trap_pc_hold", pc_out, RESET_PC);
    check("trap_retired", {16'b0, retired}, {16'b0, ret_before + 16'd1});
    mif.imem_ack   = 1'b1;
    mif.imem_rdata = 32'hCAFE_F00D;
    advance        = 1'b1;
    repeat (3) @(negedge clk);
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    advance        = 1'b0;
    check("trap_stuck_ir", instr_out, ir_before);
    check("trap_stuck_valid", {31'b0, instr_valid}, 32'd0);
    check("trap_stuck_req", {31'b0, mif.imem_req}, 32'd0);
    check("trap_stuck_retired", {16'b0, retired}, {16'b0, ret_before + 16'd1});

    // Reset leaves TRAP and clears the flag.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_trap_misaligned", {31'b0, misaligned}, 32'd0);
    check("post_trap_req", {31'b0, mif.imem_req}, 32'd1);
    fetch(32'h0000_0033, 0, 11'h033);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, giving the sequential PC increment in bytes.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-007 imem_addr  output  32  byte address of the requested word, equal to pc_out.
REQ-008 imem_ack  input  1  one-cycle pulse: imem_rdata is valid in this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_out  output  32  instruction register contents.
REQ-011 ctrl_field  output  11  {instr_out[31], instr_out[14:12], instr_out[6:0]}, consumed by the control decoder.
REQ-012 pc_out  output  32  address of the instruction in instr_out, or of the pending fetch.
REQ-013 instr_valid  output  1  instr_out/ctrl_field hold a valid instruction.
REQ-014 advance  input  1  consumer has executed the current instruction; sampled only while instr_valid.
REQ-015 branch_taken  input  1  control Branch output, qualified by the ALU zero flag, sampled with advance.
REQ-016 branch_offset  input  32  sign-extended branch immediate in bytes, sampled with advance.
REQ-017 misaligned  output  1  sticky flag: a taken-branch target had target[1:0] != 2'b00.
REQ-018 retired  output  16  count of instructions advanced past.

Function
REQ-019 The FSM SHALL have states FETCH, VALID and TRAP, encoded as 2'b00, 2'b01 and 2'b10.
REQ-020 FETCH: imem_req=1 and instr_valid=0; on imem_ack, the IR SHALL load imem_rdata and the FSM SHALL go to VALID on the next edge.
REQ-021 FETCH without imem_ack SHALL remain in FETCH with imem_addr stable; there is no timeout.
REQ-022 VALID: imem_req=0 and instr_valid=1; instr_out, ctrl_field and pc_out SHALL be stable until advance.
REQ-023 VALID with advance=1 and branch_taken=0: pc SHALL become pc+PC_STEP, retired SHALL increment, and the FSM SHALL go to FETCH.
REQ-024 VALID with advance=1 and branch_taken=1: the target SHALL be pc+branch_offset, computed with 32-bit two's-complement wrap-around.
REQ-025 If that target has target[1:0]==2'b00, pc SHALL load it, retired SHALL increment, and the FSM SHALL go to FETCH.
REQ-026 If that target has target[1:0]!=2'b00, pc SHALL hold, misaligned SHALL set, retired SHALL increment, and the FSM SHALL go to TRAP.
REQ-027 Sequential PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.
REQ-028 TRAP: imem_req=0 and instr_valid=0; TRAP SHALL be left only by reset.
REQ-029 advance, branch_taken and branch_offset SHALL be ignored outside VALID.
REQ-030 imem_ack SHALL be ignored outside FETCH; a stray ack SHALL NOT change the IR.
REQ-031 advance and imem_ack SHALL never be acted on in the same cycle; only the input for the current state SHALL take effect.
REQ-032 retired SHALL wrap 16'hFFFF -> 16'h0000.
REQ-033 ctrl_field SHALL be purely combinational from the IR, adding zero latency.
REQ-034 Minimum fetch-to-valid latency SHALL be 1 cycle after the ack edge; minimum instruction throughput SHALL be one instruction per 2 cycles with a zero-wait memory.

Reset
REQ-035 On rst: state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (NOP), misaligned=0 and retired=0.
REQ-036 Output values during and immediately after rst SHALL follow from REQ-035: imem_req=1 and instr_valid=0.
REQ-037 Reset asserted mid-FETCH SHALL drop the outstanding request; an imem_ack arriving in the first cycle after reset release SHALL be accepted as the response for RESET_PC.
REQ-038 Reset SHALL clear TRAP and misaligned.

Verification
REQ-039 Reset, then ack with rdata 32'h0000_0033 -> next cycle instr_valid=1, ctrl_field=11'b0_000_0110011, pc_out=0.
REQ-040 Three sequential advances with 2-cycle ack latency -> pc_out 0, 4, 8, C and retired=3; imem_addr stable while each ack is pending.
REQ-041 At pc=32'h10, advance with branch_taken=1 and offset=32'hFFFF_FFF8 -> next fetch address 32'h8.
REQ-042 Advance with branch_taken=1 and offset=32'h6 -> misaligned=1, state TRAP, imem_req=0; a later ack or advance has no effect.
REQ-043 Advance held high during FETCH and stray ack during VALID -> no pc, IR or retired change.
REQ-044 rst pulsed during VALID at pc=32'h20 -> imem_req=1, pc_out=RESET_PC, instr_valid=0, retired=0.
